// File: rtl/adc_t0_framer.sv
// adc_t0_framer
//   Buffers the free-running ADC sample stream in a first-word-fall-through
//   FIFO and presents it as a valid/ready stream to the blade_top t0 port.
//   The output is framed into FRAME_LEN-word packets (t0_last marks the final
//   word). Samples that arrive while the FIFO is full are dropped. Drops are
//   counted and flagged for telemetry.
//
// Ports
//   clk, MIB_MASTER_RESET       clock, async active-high reset
//   i_data_adc/i_data_valid_adc ADC sample and strobe (cannot be stalled)
//   i_enable                    capture gate
//   i_clear_stats               pulse: clears o_overflow / o_drop_count
//   t0_data/t0_valid/t0_ready   output stream
//   t0_last                     final word of each frame
//   o_overflow, o_drop_count    sticky drop flag, saturating drop count
//   o_fill_level                FIFO occupancy 0..DEPTH
//
// Handshake: a word transfers on a rising edge where t0_valid & t0_ready.
// t0_valid comes from the registered count only, so it never depends on
// t0_ready. While t0_valid is high, t0_data and t0_last hold until taken.
module adc_t0_framer #(
   parameter int DEPTH     = 64,
   parameter int FRAME_LEN = 1024,
   parameter int CNT_W     = 16,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              MIB_MASTER_RESET,
   input  logic [31:0]       i_data_adc,
   input  logic              i_data_valid_adc,
   input  logic              i_enable,
   input  logic              i_clear_stats,
   output logic [31:0]       t0_data,
   output logic              t0_valid,
   input  logic              t0_ready,
   output logic              t0_last,
   output logic              o_overflow,
   output logic [CNT_W-1:0]  o_drop_count,
   output logic [ADDR_W:0]   o_fill_level
);

   localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FRM_W-1:0]  FRM_MAX = FRM_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [31:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       data_q, data_d;
   logic [FRM_W-1:0]  frame_q, frame_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              ovf_q, ovf_d;
   logic              full, wr, rd, drop;

   assign t0_valid     = (count_q != '0);
   assign t0_data      = data_q;
   assign t0_last      = t0_valid & (frame_q == FRM_MAX);
   assign o_fill_level = count_q;
   assign o_overflow   = ovf_q;
   assign o_drop_count = drop_cnt_q;

   always_comb begin
      full = (count_q == DEPTH_C);
      rd   = t0_valid & t0_ready;
      wr   = i_data_valid_adc & i_enable & (~full | rd);
      drop = i_data_valid_adc & i_enable & full & ~rd;

      wr_ptr_d = wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d = rd ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

      count_d = count_q;
      case ({wr, rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // The head register tracks the entry at the next read pointer. If that
      // entry is being written in this same cycle (FIFO empty, or holding a
      // single word that is being read), take it straight from the input.
      // When the FIFO goes empty the last word stays on t0_data.
      data_d = data_q;
      if (count_d != '0) begin
         if (wr && (wr_ptr_q == rd_ptr_d)) data_d = i_data_adc;
         else                              data_d = mem_q[rd_ptr_d];
      end

      frame_d = frame_q;
      if (rd) frame_d = (frame_q == FRM_MAX) ? '0 : frame_q + FRM_W'(1);

      // Clear wins over a drop, but a drop in the clear cycle still counts.
      drop_cnt_d = drop_cnt_q;
      ovf_d      = ovf_q;
      if (i_clear_stats) begin
         drop_cnt_d = drop ? CNT_W'(1) : '0;
         ovf_d      = drop;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= i_data_adc;
   end

   always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
      if (MIB_MASTER_RESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_q     <= '0;
         frame_q    <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_q     <= data_d;
         frame_q    <= frame_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_adc_t0_framer.sv
// Testbench for adc_t0_framer. The main instance uses DEPTH=64, FRAME_LEN=4.
// A second small instance (DEPTH=4, FRAME_LEN=1, CNT_W=3) shares the inputs
// and covers drop-count saturation and single-word frames.
module tb_adc_t0_framer;

   localparam int DEPTH = 64;
   localparam int FL    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_data_adc = '0;
   logic        i_data_valid_adc = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_clear_stats = 1'b0;
   logic        t0_ready = 1'b0;

   logic [31:0] t0_data;
   logic        t0_valid, t0_last, o_overflow;
   logic [15:0] o_drop_count;
   logic [6:0]  o_fill_level;

   logic [31:0] s_data;
   logic        s_valid, s_last, s_ovf;
   logic [2:0]  s_drop, s_fill;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   int          mcount = 0;
   int          mframe = 0;
   int          mdrops = 0;
   logic        movf = 1'b0;
   logic        dr, dl;

   always #5 clk = ~clk;

   adc_t0_framer #(.DEPTH(DEPTH), .FRAME_LEN(FL), .CNT_W(16)) u_dut (
      .clk(clk), .MIB_MASTER_RESET(rst),
      .i_data_adc(i_data_adc), .i_data_valid_adc(i_data_valid_adc),
      .i_enable(i_enable), .i_clear_stats(i_clear_stats),
      .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
      .t0_last(t0_last), .o_overflow(o_overflow),
      .o_drop_count(o_drop_count), .o_fill_level(o_fill_level)
   );

   adc_t0_framer #(.DEPTH(4), .FRAME_LEN(1), .CNT_W(3)) u_sat (
      .clk(clk), .MIB_MASTER_RESET(rst),
      .i_data_adc(i_data_adc), .i_data_valid_adc(i_data_valid_adc),
      .i_enable(i_enable), .i_clear_stats(i_clear_stats),
      .t0_data(s_data), .t0_valid(s_valid), .t0_ready(t0_ready),
      .t0_last(s_last), .o_overflow(s_ovf),
      .o_drop_count(s_drop), .o_fill_level(s_fill)
   );

   // One clock of stimulus. At the falling edge the outputs reflect the
   // previous rising edge, so they are checked against the model first, then
   // new inputs are applied and the model advances to the next rising edge.
   task automatic drive(input logic v, input logic en, input logic [31:0] d,
                        input logic rdy, input logic clr,
                        output logic rd_o, output logic last_o);
      logic rd, wr, drop;
      logic [31:0] e;
      @(negedge clk);
      checks++;
      if (t0_valid !== (mcount != 0)) begin
         errors++; $display("FAIL valid got %0b exp %0b", t0_valid, mcount != 0);
      end
      checks++;
      if (o_fill_level !== 7'(mcount)) begin
         errors++; $display("FAIL fill got %0d exp %0d", o_fill_level, mcount);
      end
      checks++;
      if (t0_last !== ((mcount != 0) && (mframe == FL - 1))) begin
         errors++; $display("FAIL last got %0b exp %0b", t0_last, (mcount != 0) && (mframe == FL - 1));
      end
      checks++;
      if (o_drop_count !== 16'(mdrops) || o_overflow !== movf) begin
         errors++; $display("FAIL stats got %0d/%0b exp %0d/%0b", o_drop_count, o_overflow, mdrops, movf);
      end
      rd     = (mcount != 0) && rdy;
      wr     = v && en && ((mcount < DEPTH) || rd);
      drop   = v && en && (mcount == DEPTH) && !rd;
      rd_o   = rd;
      last_o = t0_last;
      if (rd) begin
         e = exp_q.pop_front();
         checks++;
         if (t0_data !== e) begin
            errors++; $display("FAIL data got %0h exp %0h", t0_data, e);
         end
         mframe = (mframe + 1) % FL;
      end
      if (wr) exp_q.push_back(d);
      mcount = mcount + (wr ? 1 : 0) - (rd ? 1 : 0);
      if (clr) begin
         mdrops = drop ? 1 : 0;
         movf   = drop;
      end else if (drop) begin
         movf = 1'b1;
         mdrops++;
      end
      i_data_valid_adc = v;
      i_enable         = en;
      i_data_adc       = d;
      t0_ready         = rdy;
      i_clear_stats    = clr;
   endtask

   task automatic model_reset();
      exp_q.delete();
      mcount = 0; mframe = 0; mdrops = 0; movf = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (t0_valid !== 1'b0 || t0_last !== 1'b0 || t0_data !== 32'h0) begin
         errors++; $display("FAIL reset_out got v%0b l%0b d%0h exp 0", t0_valid, t0_last, t0_data);
      end
      checks++;
      if (o_fill_level !== 7'd0 || o_drop_count !== 16'd0 || o_overflow !== 1'b0) begin
         errors++; $display("FAIL reset_stats got f%0d c%0d o%0b exp 0", o_fill_level, o_drop_count, o_overflow);
      end
      checks++;
      if (s_fill !== 3'd0 || s_valid !== 1'b0 || s_data !== 32'h0) begin
         errors++; $display("FAIL reset_sat got f%0d v%0b exp 0", s_fill, s_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_framing();
      int idx = 0;
      logic [11:0] mask = '0;
      for (int i = 0; i < 16; i++) begin
         drive(i < 12, 1'b1, 32'hC00 + 32'(i), 1'b1, 1'b0, dr, dl);
         if (dr) begin
            if (dl && idx < 12) mask[idx] = 1'b1;
            idx++;
         end
      end
      checks++;
      if (idx != 12 || mask !== 12'h888) begin
         errors++; $display("FAIL framing got n%0d m%0h exp n12 m888", idx, mask);
      end
   endtask

   task automatic test_latency();
      // Written at an edge, the word must be valid at the very next edge.
      drive(1'b1, 1'b1, 32'hA0, 1'b1, 1'b0, dr, dl);
      drive(1'b1, 1'b1, 32'hA1, 1'b1, 1'b0, dr, dl);
      checks++;
      if (dr !== 1'b1) begin
         errors++; $display("FAIL latency got rd %0b exp 1", dr);
      end
      drive(1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, dr, dl);
      // Gate low: strobes are ignored, FIFO drains.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'hBAD0 + 32'(i), 1'b1, 1'b0, dr, dl);
      checks++;
      if (o_fill_level !== 7'd0 || o_drop_count !== 16'd0) begin
         errors++; $display("FAIL enable_low got f%0d c%0d exp 0", o_fill_level, o_drop_count);
      end
   endtask

   task automatic test_overflow();
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, dr, dl);
      for (int i = 0; i < 70; i++)
         drive(1'b1, 1'b1, 32'h1000 + 32'($urandom_range(0, 255)) * 256 + 32'(i), 1'b0, 1'b0, dr, dl);
      @(posedge clk); #1;
      checks++;
      if (o_fill_level !== 7'd64 || o_drop_count !== 16'd6 || o_overflow !== 1'b1) begin
         errors++; $display("FAIL overflow got f%0d c%0d o%0b exp f64 c6 o1", o_fill_level, o_drop_count, o_overflow);
      end
      checks++;
      if (s_fill !== 3'd4 || s_drop !== 3'd7 || s_ovf !== 1'b1) begin
         errors++; $display("FAIL saturate got f%0d c%0d o%0b exp f4 c7 o1", s_fill, s_drop, s_ovf);
      end
      for (int i = 0; i < 66; i++) drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, dr, dl);
      checks++;
      if (exp_q.size() != 0 || o_fill_level !== 7'd0) begin
         errors++; $display("FAIL drain got f%0d q%0d exp 0", o_fill_level, exp_q.size());
      end
      checks++;
      if (s_last !== s_valid) begin
         errors++; $display("FAIL sat_last got %0b exp %0b", s_last, s_valid);
      end
   endtask

   task automatic test_full_read();
      for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, dr, dl);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 32'h3000 + 32'(i), 1'b1, 1'b0, dr, dl);
      @(posedge clk); #1;
      checks++;
      if (o_fill_level !== 7'd64 || o_drop_count !== 16'd6) begin
         errors++; $display("FAIL full_read got f%0d c%0d exp f64 c6", o_fill_level, o_drop_count);
      end
   endtask

   task automatic test_clear();
      drive(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b1, dr, dl);
      @(posedge clk); #1;
      checks++;
      if (o_drop_count !== 16'd1 || o_overflow !== 1'b1) begin
         errors++; $display("FAIL clear_drop got c%0d o%0b exp c1 o1", o_drop_count, o_overflow);
      end
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, dr, dl);
      @(posedge clk); #1;
      checks++;
      if (o_drop_count !== 16'd0 || o_overflow !== 1'b0) begin
         errors++; $display("FAIL clear got c%0d o%0b exp 0", o_drop_count, o_overflow);
      end
      for (int i = 0; i < 70; i++) drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, dr, dl);
   endtask

   task automatic test_mid_reset();
      int idx = 0;
      logic [3:0] mask = '0;
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0, dr, dl);
      drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, dr, dl);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, dr, dl);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (t0_valid !== 1'b0 || t0_last !== 1'b0 || t0_data !== 32'h0 || o_fill_level !== 7'd0) begin
         errors++; $display("FAIL mid_reset got v%0b l%0b d%0h f%0d exp 0", t0_valid, t0_last, t0_data, o_fill_level);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(i < 4, 1'b1, 32'h5000 + 32'(i), 1'b1, 1'b0, dr, dl);
         if (dr) begin
            if (dl && idx < 4) mask[idx] = 1'b1;
            idx++;
         end
      end
      checks++;
      if (idx != 4 || mask !== 4'b1000) begin
         errors++; $display("FAIL post_reset_frame got n%0d m%0b exp n4 m1000", idx, mask);
      end
   endtask

   initial begin
      test_reset();
      test_framing();
      test_latency();
      test_overflow();
      test_full_read();
      test_clear();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
